frequent_generator: RTL and testbench

Programmable square-wave source on the 8-bit Avalon-MM control bus, the transmit-side counterpart of the frequency-measurement block. A 32-bit phase accumulator clocked by the system clock drives `frequent_out` from its MSB, giving f_out = inc × f_clk / 2^32. An optional burst mode emits a programmed number of output periods and then stops. Typical use is as a stimulus source for the frequency-measurement path and as a motor or test tone source.

---
 rtl/frequent_generator.sv | 174 +++++++++++++++++
 tb/tb_frequent_generator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequent_generator.sv
// Phase-accumulator square-wave source with an 8-bit Avalon-MM register file.
// Define FREQUENT_GENERATOR_BURST_EN to add burst mode (burst count registers, DONE state).
//   state | meaning
//   IDLE  | accumulator held at 0, output low
//   RUN   | accumulating every clock, output is the registered acc[31]
//   DONE  | burst finished, output low until enable is cleared
module frequent_generator (
    input  logic       csi_MCLK_clk,
    input  logic       rsi_MRST_reset_n,
    input  logic [3:0] avs_ctrl_address,
    input  logic [7:0] avs_ctrl_writedata,
    input  logic       avs_ctrl_write,
    input  logic       avs_ctrl_read,
    output logic [7:0] avs_ctrl_readdata,
    output logic       frequent_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
`ifdef FREQUENT_GENERATOR_BURST_EN
        , DONE = 2'd2
`endif
    } state_t;

    state_t      state, state_next;
    logic [31:0] shadow, inc, acc, acc_sum, acc_next;
    logic        enable, pending, out_next;
    logic        ctrl_wr, commit, phase_clr, shadow_wr;
    logic        mode_rd, done_rd;
    logic [7:0]  rd_mux;

    assign ctrl_wr   = avs_ctrl_write && (avs_ctrl_address == 4'd8);
    assign commit    = ctrl_wr && avs_ctrl_writedata[1];
    assign phase_clr = ctrl_wr && avs_ctrl_writedata[3];
    assign shadow_wr = avs_ctrl_write && (avs_ctrl_address[3:2] == 2'b00);
    assign acc_sum   = acc + inc;

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            shadow  <= '0;
            inc     <= '0;
            enable  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (shadow_wr) begin
                shadow[{avs_ctrl_address[1:0], 3'b000} +: 8] <= avs_ctrl_writedata;
                pending <= 1'b1;
            end
            if (ctrl_wr) begin
                enable <= avs_ctrl_writedata[0];
            end
            if (commit) begin
                inc     <= shadow;
                pending <= 1'b0;
            end
        end
    end

`ifdef FREQUENT_GENERATOR_BURST_EN
    logic [31:0] burst, bcnt;
    logic        mode, last_pulse, burst_wr, rise, fall;

    assign burst_wr = avs_ctrl_write && (avs_ctrl_address[3:2] == 2'b01);
    assign rise     = !acc[31] && acc_sum[31];
    assign fall     = acc[31] && !acc_sum[31];
    assign mode_rd  = mode;
    assign done_rd  = (state == DONE);

    // bcnt is loaded only on IDLE->RUN, so burst writes during a run apply to the next one
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            burst      <= '0;
            bcnt       <= '0;
            mode       <= 1'b0;
            last_pulse <= 1'b0;
        end else begin
            if (burst_wr) begin
                burst[{avs_ctrl_address[1:0], 3'b000} +: 8] <= avs_ctrl_writedata;
            end
            if (ctrl_wr) begin
                mode <= avs_ctrl_writedata[2];
            end
            if (state == IDLE && state_next == RUN) begin
                bcnt       <= burst;
                last_pulse <= 1'b0;
            end else if (state == RUN && mode && rise && bcnt != '0) begin
                bcnt <= bcnt - 32'd1;
                if (bcnt == 32'd1) begin
                    last_pulse <= 1'b1;
                end
            end
        end
    end
`else
    assign mode_rd = 1'b0;
    assign done_rd = 1'b0;
`endif

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            state        <= IDLE;
            acc          <= '0;
            frequent_out <= 1'b0;
        end else begin
            state        <= state_next;
            acc          <= acc_next;
            frequent_out <= out_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end
`ifdef FREQUENT_GENERATOR_BURST_EN
                // leave on the falling edge after the final rise so the last pulse is full width
                else if (mode && ((bcnt == '0 && !last_pulse) || (last_pulse && fall))) begin
                    state_next = DONE;
                end
`endif
            end
`ifdef FREQUENT_GENERATOR_BURST_EN
            DONE: begin
                if (!enable) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // output keeps following acc[31] on the RUN->DONE edge; only a cleared enable drops it at once
    always_comb begin
        acc_next = '0;
        out_next = 1'b0;
        if (state == RUN && enable) begin
            out_next = acc[31];
        end
        if (state == RUN && state_next == RUN) begin
            acc_next = acc_sum;
        end
        if (phase_clr) begin
            acc_next = '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_ctrl_address)
            4'd0, 4'd1, 4'd2, 4'd3: rd_mux = shadow[{avs_ctrl_address[1:0], 3'b000} +: 8];
`ifdef FREQUENT_GENERATOR_BURST_EN
            4'd4, 4'd5, 4'd6, 4'd7: rd_mux = burst[{avs_ctrl_address[1:0], 3'b000} +: 8];
`endif
            4'd8:    rd_mux = {5'd0, mode_rd, 1'b0, enable};
            4'd9:    rd_mux = {5'd0, pending, done_rd, (state == RUN)};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            avs_ctrl_readdata <= '0;
        end else if (avs_ctrl_read && !avs_ctrl_write) begin
            avs_ctrl_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_frequent_generator.sv
// Bench for frequent_generator: read-back scoreboard plus waveform measurements.
// Burst checks are built when FREQUENT_GENERATOR_BURST_EN is defined, disabled-feature checks otherwise.
module tb_frequent_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] writedata = '0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] readdata;
    logic       fout;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic       read_seen = 1'b0;

    frequent_generator dut (
        .csi_MCLK_clk       (clk),
        .rsi_MRST_reset_n   (rst_n),
        .avs_ctrl_address   (address),
        .avs_ctrl_writedata (writedata),
        .avs_ctrl_write     (write),
        .avs_ctrl_read      (read),
        .avs_ctrl_readdata  (readdata),
        .frequent_out       (fout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) read_seen <= read && !write && rst_n;

    // monitor: every accepted read presents data one cycle later
    always @(negedge clk) begin
        if (read_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got 0x%02h with no expected value queued", readdata);
            end else begin
                logic [7:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (readdata !== e) begin
                    errors++;
                    $display("FAIL %s: got 0x%02h expected 0x%02h", nm, readdata, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic window(input int n, output int rises, output int highs);
        logic prev;
        prev  = fout;
        rises = 0;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (fout && !prev) rises++;
            if (fout) highs++;
            prev = fout;
        end
    endtask

    task automatic min_run(input int n, output int mn);
        logic cur;
        int   run;
        bit   first;
        cur   = fout;
        run   = 0;
        first = 1'b1;
        mn    = 1000;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (fout == cur) begin
                run++;
            end else begin
                if (!first && run < mn) mn = run;
                first = 1'b0;
                cur   = fout;
                run   = 1;
            end
        end
    endtask

    task automatic wait_high(input int budget, output int cycles);
        cycles = 0;
        while (!fout && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    int r, h, c, mn;

    initial begin
        // reset
        idle(2);
        chk("reset_readdata", int'(readdata), 0);
        chk("reset_out", int'(fout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 10; a++) rd(4'(a), 8'h00, $sformatf("reset_rd_addr%0d", a));

        // continuous 0x40000000
        wr(4'd3, 8'h40);
        rd(4'd9, 8'h04, "status_pending_before_commit");
        wr(4'd8, 8'h02);
        rd(4'd9, 8'h00, "status_after_commit");
        wr(4'd8, 8'h01);
        wait_high(20, c);
        chk("enable_to_first_high", c, 4);
        window(40, r, h);
        chk("cont_rises_40", r, 10);
        chk("cont_highs_40", h, 20);
        rd(4'd9, 8'h01, "status_running");
        wr(4'd0, 8'h00);
        rd(4'd9, 8'h05, "status_running_pending");
        rd(4'd8, 8'h01, "ctrl_enable_readback");

        // phase-continuous retune to 0x20000000
        wr(4'd3, 8'h20);
        wr(4'd8, 8'h03);
        min_run(64, mn);
        chk("retune_no_runt", int'(mn >= 2), 1);
        window(80, r, h);
        chk("retune_rises_80", r, 10);
        chk("retune_highs_80", h, 40);
        rd(4'd9, 8'h01, "status_after_retune");

        wr(4'd8, 8'h00);
        @(negedge clk);
        chk("disable_out_low", int'(fout), 0);
        idle(2);

`ifdef FREQUENT_GENERATOR_BURST_EN
        // burst of 3 at 0x40000000
        wr(4'd3, 8'h40);
        wr(4'd4, 8'h03);
        wr(4'd8, 8'h02);
        wr(4'd8, 8'h05);
        window(60, r, h);
        chk("burst3_rises", r, 3);
        chk("burst3_highs", h, 6);
        chk("burst3_out_after", int'(fout), 0);
        rd(4'd9, 8'h02, "burst3_status_done");
        rd(4'd8, 8'h05, "burst_ctrl_readback");
        rd(4'd4, 8'h03, "burst_count_readback");
        wr(4'd8, 8'h04);
        @(negedge clk);
        rd(4'd9, 8'h00, "burst_status_after_disable");

        // burst count 0
        wr(4'd4, 8'h00);
        wr(4'd8, 8'h05);
        window(30, r, h);
        chk("burst0_rises", r, 0);
        rd(4'd9, 8'h02, "burst0_status_done");
        wr(4'd8, 8'h04);
        idle(2);

        // disable mid-burst, then re-enable for a fresh count
        wr(4'd4, 8'h03);
        wr(4'd8, 8'h05);
        wait_high(20, c);
        chk("midburst_high_seen", int'(c < 20), 1);
        wr(4'd8, 8'h04);
        @(negedge clk);
        chk("midburst_out_low", int'(fout), 0);
        rd(4'd9, 8'h00, "midburst_status_idle");
        wr(4'd8, 8'h05);
        window(60, r, h);
        chk("reburst_rises", r, 3);
        rd(4'd9, 8'h02, "reburst_status_done");
        wr(4'd8, 8'h04);
        idle(2);
`else
        // burst feature absent
        wr(4'd4, 8'h55);
        rd(4'd4, 8'h00, "noburst_addr4_reads0");
        wr(4'd8, 8'h05);
        rd(4'd8, 8'h01, "noburst_mode_reads0");
        rd(4'd9, 8'h01, "noburst_status_running");
        wr(4'd8, 8'h00);
        idle(2);
`endif

        // simultaneous read and write: write wins, readdata holds
        wr(4'd0, 8'hA5);
        rd(4'd0, 8'hA5, "shadow_byte0_readback");
        address   = 4'd8;
        writedata = 8'h01;
        write     = 1'b1;
        read      = 1'b1;
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        chk("rw_readdata_held", int'(readdata), 'hA5);
        rd(4'd8, 8'h01, "rw_write_took_effect");
        wr(4'd8, 8'h00);
        idle(2);

        // inc = 0 while running
        wr(4'd0, 8'h00);
        wr(4'd3, 8'h00);
        wr(4'd8, 8'h03);
        window(1000, r, h);
        chk("inc0_rises", r, 0);
        chk("inc0_highs", h, 0);
        rd(4'd9, 8'h01, "inc0_status_running");
        wr(4'd8, 8'h00);
        idle(2);

        // reset mid-run
        wr(4'd3, 8'h40);
        wr(4'd8, 8'h03);
        wait_high(20, c);
        chk("prereset_high_seen", int'(c < 20), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_out", int'(fout), 0);
        chk("midreset_readdata", int'(readdata), 0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(4'd9, 8'h00, "postreset_status");
        rd(4'd3, 8'h00, "postreset_shadow3");
        rd(4'd8, 8'h00, "postreset_ctrl");
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
